// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, burst-bounded merge of HLS output streams
// onto one registered leaf-interface user output lane.
//
// Ports:
//   clk_user      user clock, rising edge
//   reset_n       async active-low reset
//   req_data      NUM_REQ packed payloads, stream i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_vld       per-stream valid
//   req_ack       per-stream acknowledge (combinational, one-hot or zero)
//   out_data      registered payload to the interface
//   out_vld       registered valid
//   out_ack       acknowledge from the interface
//   out_port      index of the stream that produced out_data
//   grant_active  high while a stream holds the grant
module leaf_out_arbiter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = 2,
    parameter int MAX_BURST    = 16
) (
    input  logic                            clk_user,
    input  logic                            reset_n,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    output logic                            out_vld,
    input  logic                            out_ack,
    output logic [REQ_BITS-1:0]             out_port,
    output logic                            grant_active
);

    localparam int SLOTS    = 2 ** REQ_BITS;
    localparam int CNT_BITS = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(MAX_BURST - 1);
    localparam logic [REQ_BITS:0]   NREQ_W    = (REQ_BITS + 1)'(NUM_REQ);
    localparam logic [REQ_BITS-1:0] LAST_IDX  = REQ_BITS'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state;
    logic [REQ_BITS-1:0] rr_ptr;
    logic [REQ_BITS-1:0] grant_idx;
    logic [CNT_BITS-1:0] burst_cnt;

    // Request vectors padded to the full tag space so that any tag value
    // indexes them safely; padding slots are never valid.
    logic [SLOTS-1:0]        vld_ext;
    logic [SLOTS-1:0]        ack_ext;
    logic [PAYLOAD_BITS-1:0] words [SLOTS];

    logic                    can_load;
    logic                    grant_vld;
    logic                    xfer;
    logic                    release_now;
    logic                    pick_hit;
    logic [REQ_BITS-1:0]     pick_idx;
    logic [REQ_BITS-1:0]     next_ptr;
    logic [PAYLOAD_BITS-1:0] word_sel;

    always_comb begin
        vld_ext              = '0;
        vld_ext[NUM_REQ-1:0] = req_vld;
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_words
        if (g < NUM_REQ) begin : g_real
            assign words[g] = req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
        end else begin : g_pad
            assign words[g] = '0;
        end
    end

    assign can_load  = !out_vld || out_ack;
    assign grant_vld = vld_ext[grant_idx];
    assign word_sel  = words[grant_idx];

    // Reset gating keeps the acks quiet for the whole time reset_n is low,
    // not just from the first edge after assertion.
    always_comb begin
        ack_ext = '0;
        if (reset_n && state == GRANT && can_load) begin
            ack_ext[grant_idx] = 1'b1;
        end
    end

    assign req_ack = ack_ext[NUM_REQ-1:0];

    assign xfer        = grant_vld && ack_ext[grant_idx];
    assign release_now = !grant_vld || (xfer && burst_cnt == LAST_BEAT);
    assign next_ptr    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Cyclic search starting at rr_ptr; the wrap is done at NUM_REQ rather
    // than at the tag width so non-power-of-two counts never reach a
    // nonexistent slot.
    always_comb begin
        logic [REQ_BITS:0] cand;
        pick_hit = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (REQ_BITS + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_hit && vld_ext[cand[REQ_BITS-1:0]]) begin
                pick_hit = 1'b1;
                pick_idx = cand[REQ_BITS-1:0];
            end
        end
    end

    // Output register: a load and a drain in the same cycle keep out_vld
    // high so a burst streams at one word per cycle.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_port <= '0;
        end else if (xfer) begin
            out_vld  <= 1'b1;
            out_data <= word_sel;
            out_port <= grant_idx;
        end else if (out_ack) begin
            out_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            burst_cnt    <= '0;
            grant_active <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state        <= GRANT;
                        grant_idx    <= pick_idx;
                        burst_cnt    <= '0;
                        grant_active <= 1'b1;
                    end
                end
                GRANT: begin
                    // A stalled output (can_load low) with the requester
                    // still valid neither counts nor releases.
                    if (release_now) begin
                        state        <= IDLE;
                        rr_ptr       <= next_ptr;
                        grant_active <= 1'b0;
                    end else if (xfer) begin
                        burst_cnt    <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed and random stimulus for leaf_out_arbiter,
// checked against a transaction-level arbitration model.
module tb_leaf_out_arbiter;

    logic clk_user = 1'b0;
    always #5 clk_user = ~clk_user;

    logic reset_n;

    logic [127:0] rd4;
    logic [3:0]   rv4, ra4;
    logic [31:0]  od4;
    logic         ov4, oa4, ga4;
    logic [1:0]   op4;

    logic [95:0]  rd3;
    logic [2:0]   rv3, ra3;
    logic [31:0]  od3;
    logic         ov3, oa3, ga3;
    logic [1:0]   op3;

    leaf_out_arbiter #(
        .PAYLOAD_BITS(32), .NUM_REQ(4), .REQ_BITS(2), .MAX_BURST(16)
    ) dut (
        .clk_user(clk_user), .reset_n(reset_n),
        .req_data(rd4), .req_vld(rv4), .req_ack(ra4),
        .out_data(od4), .out_vld(ov4), .out_ack(oa4),
        .out_port(op4), .grant_active(ga4)
    );

    leaf_out_arbiter #(
        .PAYLOAD_BITS(32), .NUM_REQ(3), .REQ_BITS(2), .MAX_BURST(4)
    ) dut3 (
        .clk_user(clk_user), .reset_n(reset_n),
        .req_data(rd3), .req_vld(rv3), .req_ack(ra3),
        .out_data(od3), .out_vld(ov3), .out_ack(oa3),
        .out_port(op3), .grant_active(ga3)
    );

    // Model: who owns the lane (-1 = nobody), words moved in this grant,
    // where the next search starts, and the one-word output slot.
    typedef struct packed {
        int          owner;
        int          cnt;
        int          nxt;
        logic        ovld;
        logic [31:0] odata;
        int          oport;
    } model_t;

    function automatic model_t m_init();
        model_t m;
        m.owner = -1;
        m.cnt   = 0;
        m.nxt   = 0;
        m.ovld  = 1'b0;
        m.odata = '0;
        m.oport = 0;
        return m;
    endfunction

    function automatic logic [7:0] m_ack(model_t m, logic ack, logic rst);
        logic [7:0] r;
        r = 8'd0;
        if (rst && m.owner >= 0 && (!m.ovld || ack)) r = 8'd1 << m.owner;
        return r;
    endfunction

    function automatic model_t m_step(model_t m, int nreq, int mb,
                                      logic [7:0] vld, logic ack,
                                      logic [255:0] data);
        model_t n;
        logic   room;
        logic   moved;
        n     = m;
        room  = !m.ovld || ack;
        moved = 1'b0;
        if (m.owner < 0) begin
            if (ack) n.ovld = 1'b0;
            for (int k = 0; k < nreq; k++) begin
                int j;
                j = (m.nxt + k) % nreq;
                if (n.owner < 0 && vld[j]) begin
                    n.owner = j;
                    n.cnt   = 0;
                end
            end
        end else begin
            moved = vld[m.owner] && room;
            if (moved) begin
                n.ovld  = 1'b1;
                n.odata = data[m.owner*32 +: 32];
                n.oport = m.owner;
                n.cnt   = m.cnt + 1;
            end else if (ack) begin
                n.ovld = 1'b0;
            end
            if (!vld[m.owner] || (moved && n.cnt == mb)) begin
                n.owner = -1;
                n.nxt   = (m.owner + 1) % nreq;
            end
        end
        return n;
    endfunction

    model_t      m4, m3;
    int          sent4 [4];
    int          lim4  [4];
    logic [31:0] base4 [4];
    int          sent3 [3];
    logic [3:0]  w4;
    logic [2:0]  w3;
    logic        a4, a3;
    logic [3:0]  last_ack4;
    int          cyc;
    int          obs4p [$];
    int          obs4c [$];
    logic [31:0] obs4d [$];
    int          obs3p [$];
    int          port3_seen;
    int          n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks the
    // DUT against the model, advances the model and the stream sources.
    task automatic tick();
        logic [7:0] e4, e3;
        for (int i = 0; i < 4; i++) begin
            rv4[i]         = w4[i] && (sent4[i] < lim4[i]);
            rd4[i*32 +: 32] = base4[i] + 32'(sent4[i]);
        end
        for (int i = 0; i < 3; i++) begin
            rv3[i]         = w3[i];
            rd3[i*32 +: 32] = (32'(i + 1) << 24) + 32'(sent3[i]);
        end
        oa4 = a4;
        oa3 = a3;
        #1;
        e4 = m_ack(m4, a4, reset_n);
        e3 = m_ack(m3, a3, reset_n);
        chk("req_ack", 32'(ra4), 32'(e4[3:0]));
        chk("out_vld", 32'(ov4), 32'(m4.ovld));
        chk("grant_active", 32'(ga4), 32'(m4.owner >= 0));
        if (m4.ovld) begin
            chk("out_data", od4, m4.odata);
            chk("out_port", 32'(op4), 32'(m4.oport));
        end
        chk("n3_req_ack", 32'(ra3), 32'(e3[2:0]));
        chk("n3_out_vld", 32'(ov3), 32'(m3.ovld));
        if (m3.ovld) begin
            chk("n3_out_data", od3, m3.odata);
            chk("n3_out_port", 32'(op3), 32'(m3.oport));
        end
        last_ack4 = ra4;
        if (ov4 && a4) begin
            obs4p.push_back(int'(op4));
            obs4d.push_back(od4);
            obs4c.push_back(cyc);
        end
        if (ov3 && a3) begin
            obs3p.push_back(int'(op3));
            if (op3 == 2'd3) port3_seen++;
        end
        if (reset_n) begin
            m4 = m_step(m4, 4, 16, 8'(rv4), a4, 256'(rd4));
            m3 = m_step(m3, 3, 4, 8'(rv3), a3, 256'(rd3));
        end
        for (int i = 0; i < 4; i++) if (e4[i] && rv4[i]) sent4[i]++;
        for (int i = 0; i < 3; i++) if (e3[i] && rv3[i]) sent3[i]++;
        cyc++;
        @(negedge clk_user);
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic clear_obs();
        obs4p.delete();
        obs4c.delete();
        obs4d.delete();
        obs3p.delete();
    endtask

    task automatic drain();
        w4 = '0;
        w3 = '0;
        a4 = 1'b1;
        a3 = 1'b1;
        run(5);
    endtask

    initial begin
        int s0;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        port3_seen = 0;
        for (int i = 0; i < 4; i++) begin
            sent4[i] = 0;
            lim4[i]  = 1 << 30;
            base4[i] = 32'(i + 1) << 20;
        end
        for (int i = 0; i < 3; i++) sent3[i] = 0;
        w4 = '0; w3 = '0; a4 = 1'b1; a3 = 1'b1;
        rv4 = '0; rd4 = '0; oa4 = 1'b1;
        rv3 = '0; rd3 = '0; oa3 = 1'b1;
        m4 = m_init();
        m3 = m_init();
        reset_n = 1'b0;

        @(negedge clk_user);
        #1;
        chk("rst_out_vld", 32'(ov4), 32'd0);
        chk("rst_out_data", od4, 32'd0);
        chk("rst_out_port", 32'(op4), 32'd0);
        chk("rst_grant", 32'(ga4), 32'd0);
        chk("rst_req_ack", 32'(ra4), 32'd0);
        @(negedge clk_user);
        reset_n = 1'b1;

        // All streams continuously valid on both instances.
        clear_obs();
        w4 = 4'hF;
        w3 = 3'h7;
        for (int t = 0; t < 200 && obs4p.size() < 65; t++) tick();
        chk("rr4_count", 32'(obs4p.size() >= 65), 32'd1);
        for (int k = 0; k < 65; k++)
            if (k < obs4p.size())
                chk("rr4_port", 32'(obs4p[k]), 32'(k < 64 ? k / 16 : 0));
        if (obs4c.size() > 16) begin
            chk("rr4_stream", 32'(obs4c[15] - obs4c[0]), 32'd15);
            chk("rr4_gap", 32'(obs4c[16] - obs4c[15]), 32'd2);
        end
        chk("rr3_count", 32'(obs3p.size() >= 13), 32'd1);
        for (int k = 0; k < 13; k++)
            if (k < obs3p.size())
                chk("rr3_port", 32'(obs3p[k]), 32'(k < 12 ? k / 4 : 0));
        drain();

        // Single stream 2 with five words.
        clear_obs();
        base4[2] = 32'h100;
        sent4[2] = 0;
        lim4[2]  = 5;
        w4 = 4'b0100;
        tick();
        chk("ss_bubble", 32'(last_ack4[2]), 32'd0);
        tick();
        chk("ss_ack_first", 32'(last_ack4[2]), 32'd1);
        run(8);
        chk("ss_count", 32'(obs4p.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < obs4p.size()) begin
                chk("ss_data", obs4d[k], 32'h100 + 32'(k));
                chk("ss_port", 32'(obs4p[k]), 32'd2);
                if (k > 0)
                    chk("ss_rate", 32'(obs4c[k] - obs4c[k-1]), 32'd1);
            end
        lim4[2] = 1 << 30;
        clear_obs();
        w4 = 4'b1001;
        run(4);
        chk("ss_next_is3", 32'(obs4p.size() > 0 ? obs4p[0] : -1), 32'd3);
        drain();

        // Backpressure mid-burst on stream 1.
        clear_obs();
        s0 = sent4[1];
        w4 = 4'b0010;
        for (int t = 0; t < 20 && sent4[1] < s0 + 3; t++) tick();
        a4 = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("bp_hold", od4, base4[1] + 32'(s0 + 2));
            chk("bp_noack", 32'(last_ack4[1]), 32'd0);
        end
        a4 = 1'b1;
        run(6);
        chk("bp_count", 32'(obs4d.size() >= 6), 32'd1);
        foreach (obs4d[k])
            chk("bp_seq", obs4d[k], base4[1] + 32'(s0 + k));
        drain();

        // Early release of stream 0 while stream 3 waits.
        clear_obs();
        s0 = sent4[0];
        lim4[0] = s0 + 3;
        w4 = 4'b0001;
        tick();
        w4 = 4'b1001;
        run(10);
        chk("er_count", 32'(obs4p.size() >= 4), 32'd1);
        if (obs4p.size() >= 4) begin
            for (int k = 0; k < 3; k++) chk("er_port0", 32'(obs4p[k]), 32'd0);
            chk("er_port3", 32'(obs4p[3]), 32'd3);
            chk("er_gap", 32'(obs4c[3] - obs4c[2]), 32'd3);
        end
        lim4[0] = 1 << 30;
        drain();

        // Reset in the middle of a burst.
        w4 = 4'hF;
        run(8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_vld", 32'(ov4), 32'd0);
        chk("rst_mid_ack", 32'(ra4), 32'd0);
        chk("rst_mid_n3_ack", 32'(ra3), 32'd0);
        m4 = m_init();
        m3 = m_init();
        @(negedge clk_user);
        reset_n = 1'b1;
        clear_obs();
        w4 = 4'b0101;
        run(6);
        chk("rst_first_grant", 32'(obs4p.size() > 0 ? obs4p[0] : -1), 32'd0);
        drain();

        // Random traffic with random backpressure and valid drops.
        for (int t = 0; t < 600; t++) begin
            w4 = 4'($urandom);
            w3 = 3'($urandom);
            a4 = ($urandom % 4) != 0;
            a3 = ($urandom % 3) != 0;
            if (t % 100 < 40) w4 = 4'hF;
            tick();
        end
        drain();
        chk("n3_never_port3", 32'(port3_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Shares one leaf-interface user output port among NUM_REQ HLS operator output streams (ap_vld/ap_ack handshake, 32-bit payload).
- Grants are round-robin with a bounded burst.
- Output is through a one-entry register, so the shared port sees a registered valid and data and a port tag.
- Sits between several HLS output streams in a leaf and one din_leaf_user2interface/vld/ack lane of the leaf interface.

Parameters:
- PAYLOAD_BITS, 32, data width per stream
- NUM_REQ, 4, number of requesting streams (2..8)
- REQ_BITS, 2, width of the port tag; must satisfy 2^REQ_BITS >= NUM_REQ
- MAX_BURST, 16, maximum words transferred per grant (1..256)

Ports:
- clk_user  in  1  user clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_data  in  NUM_REQ*PAYLOAD_BITS  request payloads; stream i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- req_vld  in  NUM_REQ  per-stream valid.
- req_ack  out  NUM_REQ  per-stream acknowledge (combinational).
- out_data  out  PAYLOAD_BITS  registered payload to the interface.
- out_vld  out  1  registered valid.
- out_ack  in  1  acknowledge from the interface.
- out_port  out  REQ_BITS  index of the stream that produced out_data.
- grant_active  out  1  high while in GRANT (debug/perf).

Behaviour:
- Transfer rule, both sides: a word moves in a cycle where vld and ack are both high at the clock edge.
- Reset (async assert, sync release):
  - out_vld=0, out_data=0, out_port=0, grant_active=0.
  - state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0.
  - req_ack is all-zero while reset_n is low.
- Output register:
  - can_load = !out_vld || out_ack.
  - req_ack[i] = (state==GRANT) && (grant_idx==i) && can_load; all other bits are 0. At most one bit of req_ack is ever high.
  - On a request transfer, out_data and out_port load and out_vld=1 next cycle.
  - On out_ack with no load, out_vld=0 next cycle.
  - Simultaneous drain and load keeps out_vld=1 with the new data (full throughput, 1 word/cycle).
  - out_data and out_port hold stable while out_vld=1 and out_ack=0.
- State IDLE:
  - If any req_vld is set, pick the first i at or above rr_ptr (cyclic, wrapping from NUM_REQ-1 to 0) with req_vld[i]=1.
  - Register grant_idx=i, burst_cnt=0, state=GRANT.
  - No req_ack is asserted in IDLE, so there is a 1-cycle arbitration bubble.
  - If no requester is valid, stay in IDLE.
- State GRANT:
  - On each request transfer, burst_cnt increments.
  - Release when a transfer occurs with burst_cnt==MAX_BURST-1, or in any cycle where req_vld[grant_idx]=0.
  - A cycle with req_vld high but can_load low does not release; the grant holds.
  - On release: rr_ptr = (grant_idx+1) mod NUM_REQ, state=IDLE, grant_active=0 next cycle.
- Latency:
  - req_vld rising in IDLE gives req_ack at +1 cycle (if can_load) and out_vld at +2.
  - Steady-state burst throughput is 1 word/cycle.
- Fairness: a continuously valid stream waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of grants, with out_ack held high.
- Backpressure mid-burst: the grant holds, burst_cnt freezes, and no words are lost or duplicated.
- Reset mid-burst: the word in the output register is discarded and arbitration restarts at port 0.
- NUM_REQ not a power of two: rr_ptr wraps explicitly at NUM_REQ; indices at or above NUM_REQ are never granted.
- Ordering: per-stream word order is preserved; words of different grants are never interleaved within one grant.

Test Plan:
- Single stream: stream 2 presents 0x100..0x104 with vld held and out_ack=1.
  - Required: req_ack[2] first high at cycle +1.
  - out_data = 0x100..0x104 on 5 consecutive cycles, out_port=2.
  - Then stream 2 drops vld, and the arbiter goes to IDLE with rr_ptr=3.
- All four streams continuously valid, MAX_BURST=16, out_ack=1.
  - Required: grants in order 0,1,2,3,0.
  - Exactly 16 words per grant, with a 1-cycle gap between grants.
  - Each 16-word run of out_port values is constant.
- Backpressure: stream 1 bursting, out_ack held low for 5 cycles after word 3.
  - Required: out_data holds word 3, and req_ack[1]=0 for those cycles.
  - burst_cnt stays frozen, and word 4 follows when out_ack returns.
  - No duplicate and no drop.
- Early release: stream 0 sends 3 words then drops vld while stream 3 is valid.
  - Required: release after word 3, then one IDLE cycle.
  - Stream 3 is granted next, with out_port=3 on its first word.
- Reset mid-burst: assert reset_n=0 asynchronously with out_vld=1.
  - Required: out_vld=0 and req_ack=0 immediately.
  - After release, with streams 0 and 2 both valid, stream 0 is granted first.
- NUM_REQ=3, REQ_BITS=2: streams 0..2 continuously valid.
  - Required: grant sequence 0,1,2,0.
  - out_port is never 3.
